// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared encodings for the RV32I memory stage: funct3 access
//               sizes, ResultSrc selects and the memory-stage FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // ResultSrc encodings for the write-back mux
  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ_WAIT = 2'd1,
    ST_RD_WAIT  = 2'd2
  } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational load/store lane logic. Replicates store data
//               across byte lanes and builds byte enables, extracts and
//               sign/zero-extends load data, and flags misaligned accesses.
// Ports       : funct3     - access size/sign
//               addr_lo    - low two bits of the effective address
//               is_store   - byte enables are produced only for stores
//               store_data - store source register value
//               load_word  - raw word returned by data memory
//               aligned    - access is naturally aligned
//               wdata/be   - lane-replicated store data and byte enables
//               load_data  - formatted load result
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic        aligned,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Word needs 4-byte alignment, halfword 2-byte; bytes are always aligned.
  always_comb begin
    aligned = 1'b1;
    case (funct3[1:0])
      2'b10:   aligned = (addr_lo == 2'b00);
      2'b01:   aligned = ~addr_lo[0];
      default: aligned = 1'b1;
    endcase
  end

  always_comb begin
    wdata = store_data;
    be    = 4'b0000;
    case (funct3)
      F3_B: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      F3_H: begin
        wdata = {2{store_data[15:0]}};
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      F3_W: begin
        wdata = store_data;
        be    = 4'b1111;
      end
      default: begin
        wdata = store_data;
        be    = 4'b0000;
      end
    endcase
    if (!is_store) begin
      be = 4'b0000;
    end
  end

  always_comb begin
    case (addr_lo)
      2'd0:    lane_byte = load_word[7:0];
      2'd1:    lane_byte = load_word[15:8];
      2'd2:    lane_byte = load_word[23:16];
      default: lane_byte = load_word[31:24];
    endcase
    lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_W:    load_data = load_word;
      F3_BU:   load_data = {24'b0, lane_byte};
      F3_HU:   load_data = {16'b0, lane_half};
      default: load_data = 32'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM stage of the 5-stage RV32I pipeline. Issues requests on a
//               req/ready + rvalid data-memory port, formats load/store lanes,
//               stalls upstream while an access is outstanding and registers
//               the MEM/WB boundary (also the two forwarding sources).
// Ports       : ex_*        - registered execute-stage outputs (held while
//                             mem_stall is high)
//               mem_stall   - freeze upstream stages
//               dmem_*      - data-memory request/response port
//               wb_*        - MEM/WB pipeline register
//               misaligned_err - one-cycle pulse for a dropped access
// Options     : MEM_PERF_CNT_EN - adds perf_stall_cycles / perf_loads
//               counters and ports.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_write_data,
  input  logic [4:0]        ex_dr_num,
  input  logic [1:0]        ex_result_src,
  input  logic [31:0]       ex_pc_plus_4,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [2:0]        ex_funct3,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       wb_alu_result,
  output logic [31:0]       wb_read_data,
  output logic [31:0]       wb_pc_plus_4,
  output logic [4:0]        wb_dr_num,
  output logic [1:0]        wb_result_src,
  output logic              wb_reg_write,
  output logic              misaligned_err
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_loads
`endif
);

  mem_state_e  state_q, state_d;

  logic [31:0] wb_alu_result_q, wb_alu_result_d;
  logic [31:0] wb_read_data_q,  wb_read_data_d;
  logic [31:0] wb_pc_plus_4_q,  wb_pc_plus_4_d;
  logic [4:0]  wb_dr_num_q,     wb_dr_num_d;
  logic [1:0]  wb_result_src_q, wb_result_src_d;
  logic        wb_reg_write_q,  wb_reg_write_d;
  logic        misaligned_q,    misaligned_d;

  logic        mem_op;
  logic        is_store;
  logic        aligned;
  logic        load_done;
  logic        stall;
  logic        req;
  logic [31:0] load_fmt;

  assign mem_op   = ex_mem_read | ex_mem_write;
  assign is_store = ex_mem_write;

  lsu_align u_lsu_align (
    .funct3     (ex_funct3),
    .addr_lo    (ex_alu_result[1:0]),
    .is_store   (is_store),
    .store_data (ex_write_data),
    .load_word  (dmem_rdata),
    .aligned    (aligned),
    .wdata      (dmem_wdata),
    .be         (dmem_be),
    .load_data  (load_fmt)
  );

  // Request fields come straight from the held ex_* inputs, so they stay
  // stable for the whole REQ_WAIT period without extra registers.
  assign dmem_we   = is_store;
  assign dmem_addr = {ex_alu_result[ADDR_W-1:2], 2'b00};

  // Next-state, request and stall decode
  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    stall     = 1'b0;
    load_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && aligned) begin
          req = 1'b1;
          if (dmem_ready) begin
            // An accepted store retires now; a load waits for rvalid.
            if (!is_store) begin
              state_d = ST_RD_WAIT;
              stall   = 1'b1;
            end
          end else begin
            state_d = ST_REQ_WAIT;
            stall   = 1'b1;
          end
        end
      end
      ST_REQ_WAIT: begin
        req   = 1'b1;
        stall = 1'b1;
        if (dmem_ready) begin
          if (is_store) begin
            state_d = ST_IDLE;
            stall   = 1'b0;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        stall = ~dmem_rvalid;
        if (dmem_rvalid) begin
          state_d   = ST_IDLE;
          load_done = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (reset) begin
      state_d = ST_IDLE;
      req     = 1'b0;
    end
  end

  assign mem_stall = stall;
  assign dmem_req  = req;

  // MEM/WB register: capture on progress, bubble while stalled
  always_comb begin
    misaligned_d    = (state_q == ST_IDLE) && mem_op && !aligned;
    wb_alu_result_d = wb_alu_result_q;
    wb_read_data_d  = wb_read_data_q;
    wb_pc_plus_4_d  = wb_pc_plus_4_q;
    wb_result_src_d = wb_result_src_q;
    wb_dr_num_d     = 5'd0;
    wb_reg_write_d  = 1'b0;
    if (!stall) begin
      wb_alu_result_d = ex_alu_result;
      wb_pc_plus_4_d  = ex_pc_plus_4;
      wb_result_src_d = ex_result_src;
      wb_dr_num_d     = ex_dr_num;
      // A dropped misaligned access retires without writing the register file.
      wb_reg_write_d  = ex_reg_write & ~misaligned_d;
      // Only a completing load has meaningful read data; otherwise clear it.
      wb_read_data_d  = load_done ? load_fmt : 32'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      wb_alu_result_q <= 32'b0;
      wb_read_data_q  <= 32'b0;
      wb_pc_plus_4_q  <= 32'b0;
      wb_dr_num_q     <= 5'd0;
      wb_result_src_q <= RS_ALU;
      wb_reg_write_q  <= 1'b0;
      misaligned_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_read_data_q  <= wb_read_data_d;
      wb_pc_plus_4_q  <= wb_pc_plus_4_d;
      wb_dr_num_q     <= wb_dr_num_d;
      wb_result_src_q <= wb_result_src_d;
      wb_reg_write_q  <= wb_reg_write_d;
      misaligned_q    <= misaligned_d;
    end
  end

  assign wb_alu_result  = wb_alu_result_q;
  assign wb_read_data   = wb_read_data_q;
  assign wb_pc_plus_4   = wb_pc_plus_4_q;
  assign wb_dr_num      = wb_dr_num_q;
  assign wb_result_src  = wb_result_src_q;
  assign wb_reg_write   = wb_reg_write_q;
  assign misaligned_err = misaligned_q;

`ifdef MEM_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_loads_q, perf_loads_d;

  // Free-running counters; they wrap naturally at 2^32.
  always_comb begin
    perf_stall_d = perf_stall_q + {31'b0, stall};
    perf_loads_d = perf_loads_q + {31'b0, load_done};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= 32'b0;
      perf_loads_q <= 32'b0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_loads_q <= perf_loads_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_loads        = perf_loads_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage: single-cycle vector
//               table plus hand-written multi-cycle load/stall/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ex_alu_result, ex_write_data, ex_pc_plus_4;
  logic [4:0]  ex_dr_num;
  logic [1:0]  ex_result_src;
  logic        ex_mem_read, ex_mem_write, ex_reg_write;
  logic [2:0]  ex_funct3;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_alu_result, wb_read_data, wb_pc_plus_4;
  logic [4:0]  wb_dr_num;
  logic [1:0]  wb_result_src;
  logic        wb_reg_write, misaligned_err;
`ifdef MEM_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_loads;
`endif

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_alu_result  (ex_alu_result),
    .ex_write_data  (ex_write_data),
    .ex_dr_num      (ex_dr_num),
    .ex_result_src  (ex_result_src),
    .ex_pc_plus_4   (ex_pc_plus_4),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_reg_write   (ex_reg_write),
    .ex_funct3      (ex_funct3),
    .mem_stall      (mem_stall),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_ready     (dmem_ready),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .wb_alu_result  (wb_alu_result),
    .wb_read_data   (wb_read_data),
    .wb_pc_plus_4   (wb_pc_plus_4),
    .wb_dr_num      (wb_dr_num),
    .wb_result_src  (wb_result_src),
    .wb_reg_write   (wb_reg_write),
    .misaligned_err (misaligned_err)
`ifdef MEM_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_loads        (perf_loads)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_ex(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dr,
                          input logic [1:0] rs, input logic [31:0] pc4, input logic mr,
                          input logic mw, input logic rw, input logic [2:0] f3);
    ex_alu_result = alu;
    ex_write_data = wd;
    ex_dr_num     = dr;
    ex_result_src = rs;
    ex_pc_plus_4  = pc4;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_reg_write  = rw;
    ex_funct3     = f3;
  endtask

  task automatic set_nop();
    drive_ex(32'h0, 32'h0, 5'd0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
  endtask

  // Single-cycle vectors: inputs, then expected port outputs and WB register.
  typedef struct {
    logic [31:0] alu;   logic [31:0] wd;   logic [4:0] dr;  logic [1:0] rs;
    logic [31:0] pc4;   logic mr; logic mw; logic rw; logic [2:0] f3; logic rdy;
    logic        e_req; logic e_we; logic [31:0] e_addr; logic [31:0] e_wdata; logic [3:0] e_be;
    logic [31:0] e_alu; logic [31:0] e_pc4; logic [4:0] e_dr; logic [1:0] e_rs;
    logic        e_rw;  logic e_mis;
  } vec_t;

  vec_t vecs [0:8];

  // Load with immediate accept and rvalid one cycle later.
  task automatic run_load(input string nm, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input logic [31:0] exp);
    @(negedge clk);
    drive_ex(addr, 32'h0, 5'd10, 2'b01, 32'h900, 1'b1, 1'b0, 1'b1, f3);
    dmem_ready = 1'b1;
    #1;
    chk({nm, "_req"}, {31'b0, dmem_req}, 32'd1);
    chk({nm, "_be"}, {28'b0, dmem_be}, 32'h0);
    chk({nm, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    @(negedge clk);
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    #1;
    chk({nm, "_stall"}, {31'b0, mem_stall}, 32'd0);
    @(posedge clk);
    #1;
    chk({nm, "_rdata"}, wb_read_data, exp);
    chk({nm, "_rw"}, {31'b0, wb_reg_write}, 32'd1);
    @(negedge clk);
    set_nop();
  endtask

  initial begin
    int stalls;

    vecs[0] = '{32'h1234, 32'h0, 5'd5, 2'b00, 32'h8, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0,
                1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1234, 32'h8, 5'd5, 2'b00, 1'b1, 1'b0};
    vecs[1] = '{32'h103, 32'hAB, 5'd0, 2'b00, 32'hC, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1,
                1'b1, 1'b1, 32'h100, 32'hABABABAB, 4'b1000, 32'h103, 32'hC, 5'd0, 2'b00, 1'b0, 1'b0};
    vecs[2] = '{32'h106, 32'h1234CDEF, 5'd0, 2'b00, 32'h10, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1,
                1'b1, 1'b1, 32'h104, 32'hCDEFCDEF, 4'b1100, 32'h106, 32'h10, 5'd0, 2'b00, 1'b0, 1'b0};
    vecs[3] = '{32'h10C, 32'hDEADBEEF, 5'd0, 2'b00, 32'h14, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1,
                1'b1, 1'b1, 32'h10C, 32'hDEADBEEF, 4'b1111, 32'h10C, 32'h14, 5'd0, 2'b00, 1'b0, 1'b0};
    vecs[4] = '{32'h402, 32'h0, 5'd7, 2'b01, 32'h18, 1'b1, 1'b0, 1'b1, 3'b010, 1'b1,
                1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h402, 32'h18, 5'd7, 2'b01, 1'b0, 1'b1};
    vecs[5] = '{32'h200, 32'h0000BEEF, 5'd0, 2'b00, 32'h1C, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1,
                1'b1, 1'b1, 32'h200, 32'hBEEFBEEF, 4'b0011, 32'h200, 32'h1C, 5'd0, 2'b00, 1'b0, 1'b0};
    vecs[6] = '{32'h501, 32'h1111, 5'd0, 2'b00, 32'h20, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1,
                1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h501, 32'h20, 5'd0, 2'b00, 1'b0, 1'b1};
    vecs[7] = '{32'h40, 32'h0, 5'd1, 2'b10, 32'h44, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0,
                1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h40, 32'h44, 5'd1, 2'b10, 1'b1, 1'b0};
    vecs[8] = '{32'h7F0, 32'h12345678, 5'd0, 2'b00, 32'h48, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1,
                1'b1, 1'b1, 32'h7F0, 32'h78787878, 4'b0001, 32'h7F0, 32'h48, 5'd0, 2'b00, 1'b0, 1'b0};

    // Reset with an aligned store presented: request must be suppressed.
    reset = 1'b1;
    set_nop();
    drive_ex(32'h10, 32'h5A5A5A5A, 5'd2, 2'b00, 32'h4, 1'b0, 1'b1, 1'b1, 3'b010);
    dmem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_wb_alu", wb_alu_result, 32'h0);
    chk("rst_wb_rdata", wb_read_data, 32'h0);
    chk("rst_wb_pc4", wb_pc_plus_4, 32'h0);
    chk("rst_wb_dr", {27'b0, wb_dr_num}, 32'h0);
    chk("rst_wb_rs", {30'b0, wb_result_src}, 32'h0);
    chk("rst_wb_rw", {31'b0, wb_reg_write}, 32'h0);
    chk("rst_mis", {31'b0, misaligned_err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    set_nop();

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_ex(vecs[i].alu, vecs[i].wd, vecs[i].dr, vecs[i].rs, vecs[i].pc4,
               vecs[i].mr, vecs[i].mw, vecs[i].rw, vecs[i].f3);
      dmem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_stall", i), {31'b0, mem_stall}, 32'd0);
      chk($sformatf("v%0d_req", i), {31'b0, dmem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_we", i), {31'b0, dmem_we}, {31'b0, vecs[i].e_we});
        chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
        chk($sformatf("v%0d_be", i), {28'b0, dmem_be}, {28'b0, vecs[i].e_be});
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wb_alu", i), wb_alu_result, vecs[i].e_alu);
      chk($sformatf("v%0d_wb_pc4", i), wb_pc_plus_4, vecs[i].e_pc4);
      chk($sformatf("v%0d_wb_dr", i), {27'b0, wb_dr_num}, {27'b0, vecs[i].e_dr});
      chk($sformatf("v%0d_wb_rs", i), {30'b0, wb_result_src}, {30'b0, vecs[i].e_rs});
      chk($sformatf("v%0d_wb_rw", i), {31'b0, wb_reg_write}, {31'b0, vecs[i].e_rw});
      chk($sformatf("v%0d_mis", i), {31'b0, misaligned_err}, {31'b0, vecs[i].e_mis});
      chk($sformatf("v%0d_wb_rdata", i), wb_read_data, 32'h0);
    end

    // Store accepted one cycle late: one bubble, other WB fields hold.
    @(negedge clk);
    drive_ex(32'h20, 32'h55, 5'd3, 2'b00, 32'h60, 1'b0, 1'b1, 1'b0, 3'b010);
    dmem_ready = 1'b0;
    #1;
    chk("sw_wait_req", {31'b0, dmem_req}, 32'd1);
    chk("sw_wait_stall", {31'b0, mem_stall}, 32'd1);
    @(posedge clk);
    #1;
    chk("sw_bubble_dr", {27'b0, wb_dr_num}, 32'd0);
    chk("sw_bubble_rw", {31'b0, wb_reg_write}, 32'd0);
    chk("sw_bubble_hold_alu", wb_alu_result, 32'h7F0);
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    chk("sw_acc_req", {31'b0, dmem_req}, 32'd1);
    chk("sw_acc_stall", {31'b0, mem_stall}, 32'd0);
    chk("sw_acc_wdata", dmem_wdata, 32'h55);
    @(posedge clk);
    #1;
    chk("sw_done_dr", {27'b0, wb_dr_num}, 32'd3);
    chk("sw_done_alu", wb_alu_result, 32'h20);
    @(negedge clk);
    set_nop();

    // LH at 0x202: ready on the third cycle, rvalid three cycles after accept.
    // A stray rvalid while still waiting for ready must be ignored.
    stalls = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive_ex(32'h202, 32'h0, 5'd9, 2'b01, 32'h70, 1'b1, 1'b0, 1'b1, 3'b001);
      dmem_ready  = (k == 2);
      dmem_rvalid = (k == 1) || (k == 5);
      dmem_rdata  = (k == 5) ? 32'h8001_1234 : 32'h7777_7777;
      #1;
      if (mem_stall) stalls++;
      chk($sformatf("lh_c%0d_req", k), {31'b0, dmem_req}, {31'b0, (k <= 2)});
      chk($sformatf("lh_c%0d_stall", k), {31'b0, mem_stall}, {31'b0, (k < 5)});
      if (k <= 2) begin
        chk($sformatf("lh_c%0d_be", k), {28'b0, dmem_be}, 32'h0);
        chk($sformatf("lh_c%0d_addr", k), dmem_addr, 32'h200);
      end
      @(posedge clk);
      #1;
      if (k < 5) begin
        chk($sformatf("lh_c%0d_bubble_rw", k), {31'b0, wb_reg_write}, 32'd0);
        chk($sformatf("lh_c%0d_bubble_dr", k), {27'b0, wb_dr_num}, 32'd0);
      end
    end
    chk("lh_stall_cycles", stalls, 32'd5);
    chk("lh_rdata", wb_read_data, 32'hFFFF8001);
    chk("lh_rw", {31'b0, wb_reg_write}, 32'd1);
    chk("lh_dr", {27'b0, wb_dr_num}, 32'd9);
    chk("lh_rs", {30'b0, wb_result_src}, 32'h1);
    @(negedge clk);
    set_nop();
    @(posedge clk);
    #1;
    chk("lh_once_rw", {31'b0, wb_reg_write}, 32'd0);

    run_load("lbu", 32'h301, 3'b100, 32'h0000F100, 32'h000000F1);
    run_load("lb",  32'h303, 3'b000, 32'h85000000, 32'hFFFFFF85);
    run_load("lw",  32'h404, 3'b010, 32'hCAFEF00D, 32'hCAFEF00D);
    run_load("lhu", 32'h202, 3'b101, 32'h8001ABCD, 32'h00008001);
    run_load("lh0", 32'h200, 3'b001, 32'h00007FFF, 32'h00007FFF);

    // Reset while in RD_WAIT, then a stale rvalid after release.
    @(negedge clk);
    drive_ex(32'h600, 32'h0, 5'd11, 2'b01, 32'hA0, 1'b1, 1'b0, 1'b1, 3'b010);
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rmid_req", {31'b0, dmem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("rmid_wb_rw", {31'b0, wb_reg_write}, 32'd0);
    chk("rmid_wb_alu", wb_alu_result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    set_nop();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFFFFFF;
    #1;
    chk("stale_stall", {31'b0, mem_stall}, 32'd0);
    chk("stale_req", {31'b0, dmem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("stale_wb_rdata", wb_read_data, 32'h0);
    chk("stale_wb_rw", {31'b0, wb_reg_write}, 32'd0);
    @(negedge clk);
    set_nop();
    drive_ex(32'h30, 32'h1, 5'd0, 2'b00, 32'hB0, 1'b0, 1'b1, 1'b0, 3'b010);
    dmem_ready = 1'b1;
    #1;
    chk("post_rst_idle_req", {31'b0, dmem_req}, 32'd1);
    chk("post_rst_idle_stall", {31'b0, mem_stall}, 32'd0);
    @(negedge clk);
    set_nop();
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net: never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
